// File: rtl/imem_pkg.sv
// Instruction-memory sizing shared by the loader and fetch, plus the loader state encoding.
package imem_pkg;

  localparam int IMEM_WORDS = 256;
  localparam int INSN_W     = 32;
  localparam int ADDR_W     = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs four accepted bytes big-endian into one instruction word.
// Flags the fourth byte with a single-cycle word_ready.
module byte_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        data,
  output logic              word_ready,
  output logic [INSN_W-1:0] word
);

  logic [1:0]  idx;
  logic [23:0] hi;

  always_ff @(posedge clk) begin
    if (clear) begin
      idx <= 2'd0;
      hi  <= 24'd0;
    end else if (accept) begin
      idx <= idx + 2'd1;
      case (idx)
        2'd0:    hi[23:16] <= data;
        2'd1:    hi[15:8]  <= data;
        2'd2:    hi[7:0]   <= data;
        default: ;
      endcase
    end
  end

  // The fourth byte is never stored; it is merged straight into the word.
  assign word_ready = accept && (idx == 2'd3);
  assign word       = {hi, data};

endmodule

// File: rtl/imem_loader.sv
// Write side of the instruction memory: streams bytes into consecutive words from
// address 0 and keeps busy high so the core stays in reset during a load.
//
// state   | meaning
// IDLE    | waiting for start; core may run
// LOAD    | accepting bytes, writing each completed word
// FLUSH   | last write strobe is on the outputs
// DONE    | one-cycle done pulse
module imem_loader #(
  parameter int ADDR_W = imem_pkg::ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W:0]             len,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic                        byte_ready,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [imem_pkg::INSN_W-1:0] wr_data,
  output logic                        busy,
  output logic                        done
);
  import imem_pkg::*;

  ld_state_t state, state_nxt;

  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   wcnt;
  logic [ADDR_W:0]   wcnt_inc;
  logic              accept;
  logic              load_go;
  logic              word_ready;
  logic [INSN_W-1:0] word;

  assign byte_ready = (state == S_LOAD);
  assign accept     = byte_valid && byte_ready;
  assign load_go    = (state == S_IDLE) && start;
  assign wcnt_inc   = wcnt + {{ADDR_W{1'b0}}, 1'b1};

  byte_packer u_packer (
    .clk        (clk),
    .clear      (rst || load_go),
    .accept     (accept),
    .data       (byte_data),
    .word_ready (word_ready),
    .word       (word)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (len == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (word_ready && (wcnt_inc == len_q)) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      len_q   <= '0;
      wcnt    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_en <= word_ready;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
      if (word_ready) wr_data <= word;
      if (load_go) begin
        len_q   <= len;
        wcnt    <= '0;
        wr_addr <= '0;
      end else begin
        if (word_ready) wcnt <= wcnt_inc;
        // Holding at the top address keeps a full-memory load from wrapping to 0.
        if (wr_en && (wr_addr != '1)) wr_addr <= wr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
